// File: rtl/sd_image_pkg.sv
// Shared types and constants for the SD-card image loader.
package sd_image_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_RECV,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam logic        MODE_RGB888 = 1'b0;
  localparam logic        MODE_RGB565 = 1'b1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // Expand an RGB565 word to left-aligned 8-bit channels.
  function automatic rgb8_t unpack_565(input logic [15:0] w);
    rgb8_t p;
    p.r = {w[15:11], 3'b000};
    p.g = {w[10:5], 2'b00};
    p.b = {w[4:0], 3'b000};
    return p;
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port frame buffer: one write port, one registered read port (read-first).
module fb_dpram #(
  parameter int unsigned DEPTH = 76800,
  parameter int unsigned AW    = 17,
  parameter int unsigned DW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_image_loader.sv
// Streams an image from SD-card blocks into an on-chip frame buffer,
// unpacking RGB888/RGB565 bytes into reduced-depth pixels.
module sd_image_loader
  import sd_image_pkg::*;
#(
  parameter int unsigned IMG_W      = 320,
  parameter int unsigned IMG_H      = 240,
  parameter int unsigned CH_BITS    = 4,
  parameter int unsigned NUM_IMAGES = 4,
  parameter logic [31:0] IMG_STRIDE = 32'h00010000,
  localparam int unsigned SEL_W     = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  localparam int unsigned PIX_AW    = $clog2(IMG_W * IMG_H),
  localparam int unsigned DW        = 3 * CH_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        sd_data_in,
  input  logic              sd_data_valid,
  input  logic              sd_ready,
  output logic [31:0]       sd_block_addr,
  output logic              sd_read_block,
  input  logic [SEL_W-1:0]  image_select,
  input  logic              mode,
  input  logic              load_start,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [PIX_AW-1:0] addrb,
  output logic [DW-1:0]     dataOut
);

  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned BC_W  = $clog2(BLOCK_BYTES);

  state_t            state_q, state_d;
  logic              rd_d, err_d, mode_d, mode_q, start_c;
  logic [31:0]       addr_d;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_nx;
  logic [1:0]        phase_q;
  logic [7:0]        b0_q, b1_q;
  logic              wr_pend_q, wr_fire_c, byte_fire_c, last_c;
  logic [DW-1:0]     pix_q, pix_c;
  rgb8_t             rgb_c;

  // Top CH_BITS of a left-aligned 8-bit channel, zero-filled when CH_BITS > 8.
  function automatic logic [CH_BITS-1:0] reduce_ch(input logic [7:0] v);
    logic [CH_BITS+7:0] wide;
    wide = {v, {CH_BITS{1'b0}}};
    return wide[CH_BITS+7 -: CH_BITS];
  endfunction

  assign byte_fire_c = (state_q == ST_RECV) && sd_data_valid;
  assign last_c      = (mode_q == MODE_RGB565) ? (phase_q == 2'd1) : (phase_q == 2'd2);
  assign wr_fire_c   = wr_pend_q && (pix_cnt_q < CNT_W'(TOTAL));
  assign pix_cnt_nx  = pix_cnt_q + CNT_W'(wr_fire_c);

  always_comb begin
    rgb_c = (mode_q == MODE_RGB888) ? rgb8_t'({b0_q, b1_q, sd_data_in})
                                    : unpack_565({b0_q, sd_data_in});
    pix_c = {reduce_ch(rgb_c.r), reduce_ch(rgb_c.g), reduce_ch(rgb_c.b)};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    rd_d    = sd_read_block;
    addr_d  = sd_block_addr;
    err_d   = error;
    mode_d  = mode_q;
    start_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (32'(image_select) >= NUM_IMAGES) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            mode_d  = mode;
            addr_d  = 32'(image_select) * IMG_STRIDE;
            start_c = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (sd_ready) begin
          rd_d    = 1'b1;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (!sd_ready) begin
          rd_d    = 1'b0;
          state_d = ST_RECV;
        end else begin
          rd_d = 1'b1;
        end
      end
      ST_RECV: begin
        if (sd_data_valid && (byte_cnt_q == BC_W'(BLOCK_BYTES - 1))) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        addr_d  = sd_block_addr + 32'd1;
        state_d = (pix_cnt_nx == CNT_W'(TOTAL)) ? ST_DONE : ST_REQ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sd_read_block <= 1'b0;
      sd_block_addr <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      mode_q        <= MODE_RGB888;
    end else begin
      state_q       <= state_d;
      sd_read_block <= rd_d;
      sd_block_addr <= addr_d;
      busy          <= (state_d != ST_IDLE);
      done          <= (state_d == ST_DONE);
      error         <= err_d;
      mode_q        <= mode_d;
    end
  end

  // Byte counting and pixel assembly; the pack phase carries across blocks.
  always_ff @(posedge clk) begin
    if (reset || start_c) begin
      byte_cnt_q <= '0;
      pix_cnt_q  <= '0;
      phase_q    <= '0;
      wr_pend_q  <= 1'b0;
      b0_q       <= '0;
      b1_q       <= '0;
      pix_q      <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_nx;
      wr_pend_q <= 1'b0;
      if (byte_fire_c) begin
        byte_cnt_q <= byte_cnt_q + BC_W'(1);
        if (last_c) begin
          phase_q   <= '0;
          pix_q     <= pix_c;
          wr_pend_q <= 1'b1;
        end else begin
          phase_q <= phase_q + 2'd1;
          if (phase_q == 2'd0) b0_q <= sd_data_in;
          else                 b1_q <= sd_data_in;
        end
      end
    end
  end

  fb_dpram #(
    .DEPTH (TOTAL),
    .AW    (PIX_AW),
    .DW    (DW)
  ) u_fb (
    .clk   (clk),
    .we    (wr_fire_c),
    .waddr (PIX_AW'(pix_cnt_q)),
    .wdata (pix_q),
    .raddr (addrb),
    .rdata (dataOut)
  );

endmodule

// File: tb/tb_sd_image_loader.sv
// Directed bench for sd_image_loader: small 4x2 frame instance and an 86x2 two-block instance.
module tb_sd_image_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sd_data_in;
  logic        sd_data_valid, sd_ready;
  logic [1:0]  image_select;
  logic        mode, ls_a, ls_b;
  logic [7:0]  addrb;
  bit          use_b;

  logic [31:0] addr_a, addr_b;
  logic        rd_a, rd_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [11:0] dout_a, dout_b;

  logic [31:0] addr_m;
  logic        rd_m, busy_m, done_m, err_m;
  logic [11:0] dout_m;
  assign addr_m = use_b ? addr_b : addr_a;
  assign rd_m   = use_b ? rd_b   : rd_a;
  assign busy_m = use_b ? busy_b : busy_a;
  assign done_m = use_b ? done_b : done_a;
  assign err_m  = use_b ? err_b  : err_a;
  assign dout_m = use_b ? dout_b : dout_a;

  always #5 clk = ~clk;

  sd_image_loader #(.IMG_W(4), .IMG_H(2), .CH_BITS(4), .NUM_IMAGES(3)) dut_a (
    .clk(clk), .reset(reset), .sd_data_in(sd_data_in), .sd_data_valid(sd_data_valid),
    .sd_ready(sd_ready), .sd_block_addr(addr_a), .sd_read_block(rd_a),
    .image_select(image_select), .mode(mode), .load_start(ls_a),
    .busy(busy_a), .done(done_a), .error(err_a), .addrb(addrb[2:0]), .dataOut(dout_a));

  sd_image_loader #(.IMG_W(86), .IMG_H(2), .CH_BITS(4), .NUM_IMAGES(4)) dut_b (
    .clk(clk), .reset(reset), .sd_data_in(sd_data_in), .sd_data_valid(sd_data_valid),
    .sd_ready(sd_ready), .sd_block_addr(addr_b), .sd_read_block(rd_b),
    .image_select(image_select), .mode(mode), .load_start(ls_b),
    .busy(busy_b), .done(done_b), .error(err_b), .addrb(addrb), .dataOut(dout_b));

  typedef struct packed {
    logic       md;
    logic [7:0] b0, b1, b2;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[16];
  logic [7:0]  stream[1024];
  logic [31:0] blk_addr[4];
  int          ptr;
  int          n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (use_b) ls_b = v;
    else       ls_a = v;
  endtask

  task automatic wait_rd(input logic lvl, inout int cycles);
    int n = 0;
    while (rd_m !== lvl && n < 20) begin
      tick();
      cycles++;
      n++;
    end
    check("rd_handshake", 32'(rd_m), 32'(lvl));
  endtask

  task automatic read_px(input int a, output logic [11:0] d);
    addrb = 8'(a);
    tick();
    d = dout_m;
  endtask

  // One full frame load with a cooperative SD controller streaming stream[].
  task automatic run_load(input logic [1:0] sel, input logic md, input bit disturb,
                          output int cycles, output int blocks, output int dpulses);
    bit fin = 0;
    int guard = 0;
    cycles = 0; blocks = 0; dpulses = 0; ptr = 0;
    image_select = sel; mode = md;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    while (!fin && guard < 6) begin
      guard++;
      wait_rd(1'b1, cycles);
      if (blocks < 4) blk_addr[blocks] = addr_m;
      blocks++;
      sd_ready = 1'b0;
      wait_rd(1'b0, cycles);
      for (int i = 0; i < 512; i++) begin
        sd_data_in    = stream[ptr % 1024];
        sd_data_valid = 1'b1;
        ptr++;
        if (disturb && (i == 5 || i == 300)) begin
          image_select = 2'd2;
          mode = ~md;
          set_start(1'b1);
        end
        tick();
        cycles++;
        set_start(1'b0);
      end
      sd_data_valid = 1'b0;
      sd_ready = 1'b1;
      for (int k = 0; k < 4 && !fin && !rd_m; k++) begin
        tick();
        cycles++;
        if (done_m) fin = 1;
      end
    end
    check("load_finished", 32'(fin), 32'd1);
    if (fin) begin
      dpulses = 1;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (done_m) dpulses++;
      end
    end
  endtask

  initial begin
    int cyc, blks, dp;
    logic [11:0] d;
    bit any_rd;

    vecs[0]  = '{1'b0, 8'hFF, 8'h80, 8'h10, 12'hF81};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h00, 12'h000};
    vecs[2]  = '{1'b0, 8'h12, 8'h34, 8'h56, 12'h135};
    vecs[3]  = '{1'b0, 8'hAB, 8'hCD, 8'hEF, 12'hACE};
    vecs[4]  = '{1'b0, 8'h7F, 8'h80, 8'h0F, 12'h780};
    vecs[5]  = '{1'b0, 8'hF0, 8'h0F, 8'hF0, 12'hF0F};
    vecs[6]  = '{1'b0, 8'h01, 8'h23, 8'h45, 12'h024};
    vecs[7]  = '{1'b0, 8'h9C, 8'h6D, 8'h3E, 12'h963};
    vecs[8]  = '{1'b1, 8'hF8, 8'h1F, 8'h00, 12'hF0F};
    vecs[9]  = '{1'b1, 8'h07, 8'hE0, 8'h00, 12'h0F0};
    vecs[10] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 12'hFFF};
    vecs[11] = '{1'b1, 8'h00, 8'h00, 8'h00, 12'h000};
    vecs[12] = '{1'b1, 8'h84, 8'h10, 8'h00, 12'h888};
    vecs[13] = '{1'b1, 8'h12, 8'h34, 8'h00, 12'h14A};
    vecs[14] = '{1'b1, 8'h00, 8'h1F, 8'h00, 12'h00F};
    vecs[15] = '{1'b1, 8'hF8, 8'h00, 8'h00, 12'hF00};

    use_b = 0; reset = 1'b1; sd_data_in = '0; sd_data_valid = 1'b0; sd_ready = 1'b1;
    image_select = '0; mode = 1'b0; ls_a = 1'b0; ls_b = 1'b0; addrb = '0;
    tick(); tick();
    check("rst_read_block", 32'(rd_a), 32'd0);
    check("rst_block_addr", addr_a, 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_error", 32'(err_a), 32'd0);
    reset = 1'b0;
    tick();

    // Out-of-range image index: sticky error, no traffic.
    image_select = 2'd3; ls_a = 1'b1;
    tick();
    ls_a = 1'b0;
    any_rd = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_a || busy_a) any_rd = 1;
      tick();
    end
    check("err_flag", 32'(err_a), 32'd1);
    check("err_busy", 32'(busy_a), 32'd0);
    check("err_no_read", 32'(any_rd), 32'd0);

    // RGB565 load into image 0.
    for (int i = 0; i < 1024; i++) stream[i] = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      stream[2*i]   = vecs[8+i].b0;
      stream[2*i+1] = vecs[8+i].b1;
    end
    run_load(2'd0, 1'b1, 1'b0, cyc, blks, dp);
    check("565_addr", blk_addr[0], 32'h0000_0000);
    check("565_blocks", 32'(blks), 32'd1);
    check("565_cycles", 32'(cyc), 32'd515);
    check("565_done_pulses", 32'(dp), 32'd1);
    check("565_error_cleared", 32'(err_a), 32'd0);
    check("565_idle_busy", 32'(busy_a), 32'd0);
    for (int i = 0; i < 8; i++) begin
      read_px(i, d);
      check($sformatf("px565_%0d", i), 32'(d), 32'(vecs[8+i].exp));
    end

    // RGB888 load into image 1, undisturbed and then with load_start pulses mid-load.
    for (int i = 0; i < 1024; i++) stream[i] = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      stream[3*i]   = vecs[i].b0;
      stream[3*i+1] = vecs[i].b1;
      stream[3*i+2] = vecs[i].b2;
    end
    for (int pass = 0; pass < 2; pass++) begin
      run_load(2'd1, 1'b0, pass == 1, cyc, blks, dp);
      check($sformatf("888_addr_p%0d", pass), blk_addr[0], 32'h0001_0000);
      check($sformatf("888_blocks_p%0d", pass), 32'(blks), 32'd1);
      check($sformatf("888_cycles_p%0d", pass), 32'(cyc), 32'd515);
      check($sformatf("888_done_pulses_p%0d", pass), 32'(dp), 32'd1);
      for (int i = 0; i < 8; i++) begin
        read_px(i, d);
        check($sformatf("px888_p%0d_%0d", pass, i), 32'(d), 32'(vecs[i].exp));
      end
    end

    // Reset in the middle of RECV after one new pixel has been written.
    image_select = 2'd0; mode = 1'b0; ls_a = 1'b1;
    tick();
    ls_a = 1'b0;
    cyc = 0;
    wait_rd(1'b1, cyc);
    sd_ready = 1'b0;
    wait_rd(1'b0, cyc);
    for (int i = 0; i < 4; i++) begin
      sd_data_in = 8'(8'h11 * (i + 1));
      sd_data_valid = 1'b1;
      tick();
    end
    check("mid_recv_busy", 32'(busy_a), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_read_block", 32'(rd_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_block_addr", addr_a, 32'd0);
    reset = 1'b0; sd_data_valid = 1'b0; sd_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      read_px(i, d);
      check($sformatf("px_after_reset_%0d", i), 32'(d), (i == 0) ? 32'h123 : 32'(vecs[i].exp));
    end

    // 86x2 RGB888: 516 bytes span two blocks.
    use_b = 1;
    for (int i = 0; i < 1024; i++) stream[i] = (i < 516) ? 8'((i * 7 + 3) & 255) : 8'hEE;
    run_load(2'd2, 1'b0, 1'b0, cyc, blks, dp);
    check("two_blk_blocks", 32'(blks), 32'd2);
    check("two_blk_addr0", blk_addr[0], 32'h0002_0000);
    check("two_blk_addr1", blk_addr[1], 32'h0002_0001);
    check("two_blk_cycles", 32'(cyc), 32'd1030);
    check("two_blk_done_pulses", 32'(dp), 32'd1);
    foreach (blk_addr[j]) if (j < 1) begin end
    for (int t = 0; t < 5; t++) begin
      int k;
      logic [11:0] e;
      k = (t == 0) ? 0 : (t == 1) ? 85 : (t == 2) ? 169 : (t == 3) ? 170 : 171;
      e = {stream[3*k][7:4], stream[3*k+1][7:4], stream[3*k+2][7:4]};
      read_px(k, d);
      check($sformatf("two_blk_px%0d", k), 32'(d), 32'(e));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_image_loader.md
SD_IMAGE_LOADER -- requirements
Module: sd_image_loader

Interface
REQ-001 Parameter IMG_W, 320, frame width in pixels.
REQ-002 Parameter IMG_H, 240, frame height in pixels.
REQ-003 Parameter CH_BITS, 4, output bits per colour channel; dataOut width is 3*CH_BITS.
REQ-004 Parameter NUM_IMAGES, 4, number of selectable images on card.
REQ-005 Parameter IMG_STRIDE, 32'h00010000, block-address distance between consecutive image start blocks; image k starts at k*IMG_STRIDE.
REQ-006 Ports: clk in 1 system clock; reset in 1 synchronous active-high reset.
REQ-007 Ports: sd_data_in in 8 byte from SD controller; sd_data_valid in 1 byte strobe; sd_ready in 1 controller idle; sd_block_addr out 32 block to read; sd_read_block out 1 read request.
REQ-008 Ports: image_select in $clog2(NUM_IMAGES) image index; mode in 1 (0=RGB888, 1=RGB565); load_start in 1 start pulse; busy out 1; done out 1; error out 1.
REQ-009 Ports: addrb in $clog2(IMG_W*IMG_H) read address; dataOut out 3*CH_BITS pixel, registered, 1-cycle read latency.

Function
REQ-010 FSM states: IDLE, REQ, WAIT_ACK, RECV, NEXT, DONE.
REQ-011 IDLE: load_start=1 latches image_select, mode; sets sd_block_addr=image_select*IMG_STRIDE; clears pixel and byte counters; -> REQ.
REQ-012 image_select >= NUM_IMAGES at start: error=1 (sticky until next accepted start), no load, stay IDLE.
REQ-013 REQ: sd_read_block=1 while sd_ready=1; next cycle -> WAIT_ACK.
REQ-014 WAIT_ACK: sd_read_block held 1 until sd_ready=0, then deasserted, -> RECV.
REQ-015 RECV: each sd_data_valid byte increments 9-bit byte counter; after byte 511 -> NEXT; sd_data_valid outside RECV ignored.
REQ-016 NEXT: sd_block_addr+=1; if pixel counter = IMG_W*IMG_H -> DONE, else -> REQ.
REQ-017 RGB888: 3 bytes/pixel, order R,G,B; pack phase persists across block boundaries.
REQ-018 RGB565: 2 bytes/pixel, high byte first; R=[15:11], G=[10:5], B=[4:0].
REQ-019 Channel reduction: take top CH_BITS bits of each channel; if CH_BITS exceeds source width, left-align and zero-fill LSBs.
REQ-020 Frame-buffer write occurs in the cycle following the last byte of a pixel, at address = pixel counter, then counter increments.
REQ-021 Once pixel counter reaches IMG_W*IMG_H, remaining bytes of current block are consumed without writes.
REQ-022 DONE: done=1 for exactly one cycle, -> IDLE; busy=1 in all states except IDLE.
REQ-023 load_start while busy is ignored; image_select/mode changes while busy have no effect.
REQ-024 Read port independent of loader; simultaneous read and write to same address returns old data.

Reset
REQ-025 Reset: state=IDLE, sd_read_block=0, sd_block_addr=0, busy=0, done=0, error=0, counters=0, pack phase=0.
REQ-026 Reset mid-load aborts immediately; frame-buffer contents are not cleared; dataOut continues reflecting RAM.

Structure
REQ-027 Shared package sd_image_pkg holds FSM state encoding, BLOCK_BYTES=512, MODE_RGB888=0, MODE_RGB565=1.
REQ-028 Frame buffer is a single sub-module fb_dpram (one write port, one registered read port, depth IMG_W*IMG_H) inferable as block RAM.

Verification
REQ-029 IMG_W=4, IMG_H=2, RGB888, image_select=1: sd_block_addr=32'h00010000; bytes FF,80,10 -> pixel 0 = 12'hF81; done after one block, 1 pulse.
REQ-030 RGB565, bytes F8,1F -> pixel 12'hF0F; bytes 07,E0 -> 12'h0F0.
REQ-031 IMG_W=86, IMG_H=2, RGB888 (516 bytes): pixel 170 spans blocks 0/1 and is assembled correctly; exactly 2 blocks read; block 1 bytes 4..511 produce no writes.
REQ-032 image_select=3 with NUM_IMAGES=3: error=1, busy=0, sd_read_block never asserted.
REQ-033 Reset asserted mid-RECV: next cycle state IDLE, sd_read_block=0; previously written pixels read back unchanged via addrb.
REQ-034 load_start pulsed during busy: no restart, block sequence and done timing identical to undisturbed run.
